beta_pipe_ctrl: RTL and testbench
=================================

BETA_PIPE_CTRL -- requirements
Module: beta_pipe_ctrl

Parameters
REQ-001 The block SHALL have parameter DataWidth, default 32, giving the width of the stall counter.
REQ-002 The block SHALL have parameter RegAddrWidth, default 5, giving the width of register indices.

Interface
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 dec_rs1_i, dec_rs2_i  in  RegAddrWidth each  source register indices of the instruction in decode.
REQ-006 dec_rs1_used_i, dec_rs2_used_i  in  1 each  high when the corresponding source is actually read.
REQ-007 ex_rd_i  in  RegAddrWidth  destination register index of the instruction in execute.
REQ-008 ex_valid_i, ex_is_load_i  in  1 each  execute holds a valid instruction / holds a load.
REQ-009 ex_redirect_i  in  1  taken branch or jump resolved in execute.
REQ-010 mem_req_i, mem_ack_i  in  1 each  data-memory request pending / completed this cycle.
REQ-011 halt_req_i  in  1  debug halt request, level-sensitive.
REQ-012 pc_stall_o  out  1  hold the PC.
REQ-013 if_dec_stall_o, if_dec_flush_o  out  1 each  control of the IF/DEC register.
REQ-014 dec_ex_stall_o, dec_ex_flush_o  out  1 each  control of the DEC/EX register.
REQ-015 ex_mem_stall_o  out  1  hold the EX/MEM register.
REQ-016 mem_wb_flush_o  out  1  load a bubble into the MEM/WB register.
REQ-017 state_o  out  2  current FSM state.
REQ-018 stall_cnt_o  out  DataWidth  count of cycles in which pc_stall_o was high.

Function
REQ-019 The FSM SHALL have the states RUN=0, MEM_WAIT=1, REDIR=2 and HALT=3.
REQ-020 memwait = mem_req_i & ~mem_ack_i.
REQ-021 loaduse = ex_valid_i & ex_is_load_i & (ex_rd_i!=0) & ((dec_rs1_used_i & dec_rs1_i==ex_rd_i) | (dec_rs2_used_i & dec_rs2_i==ex_rd_i)).
REQ-022 Outputs SHALL be Mealy (state plus current inputs), and the rule with the highest priority SHALL win; priority order 1 to 5 follows.
- 1. memwait, in any state: pc, if_dec, dec_ex and ex_mem stalls = 1; mem_wb_flush = 1; other flushes = 0; next state = MEM_WAIT.
- 2. HALT, or RUN with halt_req_i: all stalls = 1; flushes = 0; next state = HALT while halt_req_i=1, else RUN.
- 3. ex_redirect_i in RUN or MEM_WAIT (ack cycle): if_dec_flush = 1 and dec_ex_flush = 1; stalls = 0; next state = REDIR.
- 4. REDIR: if_dec_flush = 1, discarding the wrong-path word from the 1-cycle-latency instruction memory; next state = RUN. Any ex_redirect_i seen in REDIR SHALL be re-applied as rule 3.
- 5. loaduse in RUN or MEM_WAIT: pc_stall = if_dec_stall = 1 and dec_ex_flush = 1 for exactly one cycle; next state = RUN.
- Default: all outputs = 0; next state = RUN.
REQ-023 MEM_WAIT SHALL exit to RUN on the cycle mem_ack_i=1; that cycle SHALL evaluate rules 3–5 normally.
REQ-024 A stall and a flush of the same register SHALL never be asserted together.
REQ-025 A halt_req_i raised during memwait SHALL take effect on the first cycle after mem_ack_i.
REQ-026 ex_redirect_i or loaduse present during memwait or HALT SHALL be ignored; the source stages stay frozen, so they re-present later.
REQ-027 stall_cnt_o SHALL increment by 1 on each cycle with pc_stall_o=1 and wrap modulo 2^DataWidth.
REQ-028 The latency from input to stall/flush output SHALL be zero cycles (same cycle).

Reset
REQ-029 While rst_i=1, the state SHALL be forced to RUN, stall_cnt_o to 0, and all stalls to 0.
REQ-030 While rst_i=1, if_dec_flush_o, dec_ex_flush_o and mem_wb_flush_o SHALL be 1.
REQ-031 Reset asserted mid-MEM_WAIT, mid-REDIR or mid-HALT SHALL abort the sequence; the first cycle after reset SHALL be RUN.

Structure
REQ-032 The state enum pctrl_state_t and the NOP constant 32'h00000013 SHALL be defined in beta_pkg.
REQ-033 The loaduse comparison SHALL be a combinational sub-module beta_hazard_detect.
REQ-034 The FSM, priority logic and counter SHALL be in beta_pipe_ctrl.

Verification
REQ-035 Load x5 in EX, DEC reads rs1=x5 used -> one cycle of pc_stall=if_dec_stall=dec_ex_flush=1, then all 0; stall_cnt=1.
REQ-036 Load to x0, DEC reads x0 -> no stall; rs2=x5 with rs2_used=0 -> no stall.
REQ-037 ex_redirect_i=1 for one cycle -> if_dec_flush=dec_ex_flush=1; next cycle if_dec_flush=1 only with state_o=2; then state_o=0.
REQ-038 mem_req_i=1, ack after 3 cycles, with ex_redirect_i=1 throughout -> 3 cycles with stalls=1 and mem_wb_flush=1 (state 1); ack cycle shows the redirect flush; stall_cnt=3.
REQ-039 halt_req_i for 4 cycles together with loaduse -> 4 cycles with all stalls=1 (state 3); then one loaduse bubble.
REQ-040 rst_i during MEM_WAIT -> flushes=1, stalls=0; state_o=0 and stall_cnt=0 after reset.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta pipeline control slice.
package beta_pkg;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'd0,
    PCTRL_MEM_WAIT = 2'd1,
    PCTRL_REDIR    = 2'd2,
    PCTRL_HALT     = 2'd3
  } pctrl_state_t;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage : beta_pkg

// File: rtl/beta_hazard_detect.sv
// Combinational load-use hazard detection between decode and execute.
module beta_hazard_detect
  import beta_pkg::*;
#(
  parameter int RegAddrWidth = 5
) (
  input  logic [RegAddrWidth-1:0] dec_rs1_i,
  input  logic [RegAddrWidth-1:0] dec_rs2_i,
  input  logic                    dec_rs1_used_i,
  input  logic                    dec_rs2_used_i,
  input  logic [RegAddrWidth-1:0] ex_rd_i,
  input  logic                    ex_valid_i,
  input  logic                    ex_is_load_i,
  output logic                    loaduse_o
);

  logic rd_nonzero_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  // x0 is hardwired, so a load targeting it never creates a dependency
  assign rd_nonzero_s = (ex_rd_i != {RegAddrWidth{1'b0}});
  assign rs1_hit_s    = dec_rs1_used_i & (dec_rs1_i == ex_rd_i);
  assign rs2_hit_s    = dec_rs2_used_i & (dec_rs2_i == ex_rd_i);
  assign loaduse_o    = ex_valid_i & ex_is_load_i & rd_nonzero_s & (rs1_hit_s | rs2_hit_s);

endmodule : beta_hazard_detect

// File: rtl/beta_pipe_ctrl.sv
// Pipeline stall/flush controller: priority FSM with same-cycle (Mealy) outputs
// and a counter of PC-stall cycles.
module beta_pipe_ctrl
  import beta_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RegAddrWidth-1:0] dec_rs1_i,
  input  logic [RegAddrWidth-1:0] dec_rs2_i,
  input  logic                    dec_rs1_used_i,
  input  logic                    dec_rs2_used_i,
  input  logic [RegAddrWidth-1:0] ex_rd_i,
  input  logic                    ex_valid_i,
  input  logic                    ex_is_load_i,
  input  logic                    ex_redirect_i,
  input  logic                    mem_req_i,
  input  logic                    mem_ack_i,
  input  logic                    halt_req_i,
  output logic                    pc_stall_o,
  output logic                    if_dec_stall_o,
  output logic                    if_dec_flush_o,
  output logic                    dec_ex_stall_o,
  output logic                    dec_ex_flush_o,
  output logic                    ex_mem_stall_o,
  output logic                    mem_wb_flush_o,
  output logic [1:0]              state_o,
  output logic [DataWidth-1:0]    stall_cnt_o
);

  pctrl_state_t         state_r;
  pctrl_state_t         state_next_s;
  logic [DataWidth-1:0] stall_cnt_r;
  logic                 memwait_s;
  logic                 loaduse_s;

  assign memwait_s = mem_req_i & ~mem_ack_i;

  beta_hazard_detect #(
    .RegAddrWidth (RegAddrWidth)
  ) u_hazard (
    .dec_rs1_i      (dec_rs1_i),
    .dec_rs2_i      (dec_rs2_i),
    .dec_rs1_used_i (dec_rs1_used_i),
    .dec_rs2_used_i (dec_rs2_used_i),
    .ex_rd_i        (ex_rd_i),
    .ex_valid_i     (ex_valid_i),
    .ex_is_load_i   (ex_is_load_i),
    .loaduse_o      (loaduse_s)
  );

  // Priority-ordered next state and stage controls; earlier branches win
  always_comb begin
    state_next_s   = PCTRL_RUN;
    pc_stall_o     = 1'b0;
    if_dec_stall_o = 1'b0;
    if_dec_flush_o = 1'b0;
    dec_ex_stall_o = 1'b0;
    dec_ex_flush_o = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (rst_i) begin
      if_dec_flush_o = 1'b1;
      dec_ex_flush_o = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else if (memwait_s) begin
      pc_stall_o     = 1'b1;
      if_dec_stall_o = 1'b1;
      dec_ex_stall_o = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_flush_o = 1'b1;
      state_next_s   = PCTRL_MEM_WAIT;
    end else if ((state_r == PCTRL_HALT) || ((state_r == PCTRL_RUN) && halt_req_i)) begin
      pc_stall_o     = 1'b1;
      if_dec_stall_o = 1'b1;
      dec_ex_stall_o = 1'b1;
      ex_mem_stall_o = 1'b1;
      state_next_s   = halt_req_i ? PCTRL_HALT : PCTRL_RUN;
    end else if (ex_redirect_i) begin
      // HALT is excluded above, so this covers RUN, MEM_WAIT ack and REDIR
      if_dec_flush_o = 1'b1;
      dec_ex_flush_o = 1'b1;
      state_next_s   = PCTRL_REDIR;
    end else if (state_r == PCTRL_REDIR) begin
      if_dec_flush_o = 1'b1;
      state_next_s   = PCTRL_RUN;
    end else if (loaduse_s) begin
      pc_stall_o     = 1'b1;
      if_dec_stall_o = 1'b1;
      dec_ex_flush_o = 1'b1;
      state_next_s   = PCTRL_RUN;
    end else begin
      state_next_s   = PCTRL_RUN;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= PCTRL_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC-stall cycle counter, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= {DataWidth{1'b0}};
    end else if (pc_stall_o) begin
      stall_cnt_r <= stall_cnt_r + DataWidth'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign state_o     = state_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule : beta_pipe_ctrl

// File: tb/tb_beta_pipe_ctrl.sv
// Directed self-checking bench for beta_pipe_ctrl; inputs change on the falling
// edge and outputs are checked 1 ns later.
module tb_beta_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic        rs1_used = 1'b0, rs2_used = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, redirect = 1'b0;
  logic        mem_req = 1'b0, mem_ack = 1'b0, halt = 1'b0;
  logic        pc_stall, ifd_stall, ifd_flush, dex_stall, dex_flush, exm_stall, mwb_flush;
  logic [1:0]  state;
  logic [31:0] cnt;
  logic [6:0]  ctl;

  int total = 0;
  int bad   = 0;

  // {pc_stall, if_dec_stall, if_dec_flush, dec_ex_stall, dec_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b0010101;
  localparam logic [6:0] C_MEMW  = 7'b1101011;
  localparam logic [6:0] C_HALT  = 7'b1101010;
  localparam logic [6:0] C_RDR3  = 7'b0010100;
  localparam logic [6:0] C_RDR4  = 7'b0010000;
  localparam logic [6:0] C_LDUSE = 7'b1100100;

  assign ctl = {pc_stall, ifd_stall, ifd_flush, dex_stall, dex_flush, exm_stall, mwb_flush};

  always #5 clk = ~clk;

  beta_pipe_ctrl #(.DataWidth(32), .RegAddrWidth(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .dec_rs1_i      (rs1),
    .dec_rs2_i      (rs2),
    .dec_rs1_used_i (rs1_used),
    .dec_rs2_used_i (rs2_used),
    .ex_rd_i        (rd),
    .ex_valid_i     (ex_valid),
    .ex_is_load_i   (ex_load),
    .ex_redirect_i  (redirect),
    .mem_req_i      (mem_req),
    .mem_ack_i      (mem_ack),
    .halt_req_i     (halt),
    .pc_stall_o     (pc_stall),
    .if_dec_stall_o (ifd_stall),
    .if_dec_flush_o (ifd_flush),
    .dec_ex_stall_o (dex_stall),
    .dec_ex_flush_o (dex_flush),
    .ex_mem_stall_o (exm_stall),
    .mem_wb_flush_o (mwb_flush),
    .state_o        (state),
    .stall_cnt_o    (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [6:0] c, input logic [1:0] s, input logic [31:0] n);
    chk({tag, "_ctl"}, {25'd0, ctl}, {25'd0, c});
    chk({tag, "_state"}, {30'd0, state}, {30'd0, s});
    chk({tag, "_cnt"}, cnt, n);
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk);
    #1 chk3("reset", C_RST, 2'd0, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk3("idle", C_IDLE, 2'd0, 32'd0);

    // load x5 in EX, DEC reads x5 via rs1
    @(negedge clk); ex_valid = 1'b1; ex_load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
    #1 chk3("lduse", C_LDUSE, 2'd0, 32'd0);
    @(negedge clk); ex_valid = 1'b0;
    #1 chk3("lduse_after", C_IDLE, 2'd0, 32'd1);

    // load to x0 and unused rs2 match do not stall
    @(negedge clk); ex_valid = 1'b1; rd = 5'd0; rs1 = 5'd0;
    #1 chk3("ld_x0", C_IDLE, 2'd0, 32'd1);
    @(negedge clk); rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5; rs2_used = 1'b0;
    #1 chk3("rs2_unused", C_IDLE, 2'd0, 32'd1);

    // single-cycle redirect
    @(negedge clk); ex_valid = 1'b0; redirect = 1'b1;
    #1 chk3("redir_ex", C_RDR3, 2'd0, 32'd1);
    @(negedge clk); redirect = 1'b0;
    #1 chk3("redir_st", C_RDR4, 2'd2, 32'd1);
    @(negedge clk);
    #1 chk3("redir_done", C_IDLE, 2'd0, 32'd1);

    // memwait for 3 cycles with redirect held, then ack
    @(negedge clk); mem_req = 1'b1; redirect = 1'b1;
    #1 chk3("memw1", C_MEMW, 2'd0, 32'd1);
    @(negedge clk);
    #1 chk3("memw2", C_MEMW, 2'd1, 32'd2);
    @(negedge clk);
    #1 chk3("memw3", C_MEMW, 2'd1, 32'd3);
    @(negedge clk); mem_ack = 1'b1;
    #1 chk3("memw_ack", C_RDR3, 2'd1, 32'd4);
    @(negedge clk); mem_req = 1'b0; mem_ack = 1'b0; redirect = 1'b0;
    #1 chk3("memw_redir", C_RDR4, 2'd2, 32'd4);
    @(negedge clk);
    #1 chk3("memw_done", C_IDLE, 2'd0, 32'd4);

    // halt for 4 cycles with a load-use hazard pending
    @(negedge clk); halt = 1'b1; ex_valid = 1'b1; ex_load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
    #1 chk3("halt1", C_HALT, 2'd0, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk3("halt_n", C_HALT, 2'd3, 32'd5 + 32'(i));
    end
    @(negedge clk); halt = 1'b0;
    #1 chk3("halt_exit", C_HALT, 2'd3, 32'd8);
    @(negedge clk);
    #1 chk3("halt_lduse", C_LDUSE, 2'd0, 32'd9);
    @(negedge clk); ex_valid = 1'b0;
    #1 chk3("halt_done", C_IDLE, 2'd0, 32'd10);

    // halt raised during memwait acts after the ack cycle
    @(negedge clk); mem_req = 1'b1; halt = 1'b1;
    #1 chk3("mh_wait", C_MEMW, 2'd0, 32'd10);
    @(negedge clk); mem_ack = 1'b1;
    #1 chk3("mh_ack", C_IDLE, 2'd1, 32'd11);
    @(negedge clk); mem_req = 1'b0; mem_ack = 1'b0;
    #1 chk3("mh_halt", C_HALT, 2'd0, 32'd11);
    @(negedge clk); halt = 1'b0;
    #1 chk3("mh_exit", C_HALT, 2'd3, 32'd12);
    @(negedge clk);
    #1 chk3("mh_done", C_IDLE, 2'd0, 32'd13);

    // reset in the middle of MEM_WAIT
    @(negedge clk); mem_req = 1'b1;
    #1 chk3("rm_w1", C_MEMW, 2'd0, 32'd13);
    @(negedge clk);
    #1 chk3("rm_w2", C_MEMW, 2'd1, 32'd14);
    @(negedge clk); rst = 1'b1;
    #1 chk3("rm_rst", C_RST, 2'd1, 32'd15);
    @(negedge clk);
    #1 chk3("rm_rst2", C_RST, 2'd0, 32'd0);
    @(negedge clk); rst = 1'b0; mem_req = 1'b0;
    #1 chk3("rm_after", C_IDLE, 2'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_beta_pipe_ctrl
